// File: rtl/fp32_add_share_ctrl.sv
// Purpose : round-robin share of one external combinational FP32 adder among NREQ requesters.
// Latency : handshake at edge k -> resp_valid after edge k+1; 1 op/cycle with resp_ready held high.
// Backpr. : result stage stalls on !resp_ready; operand stage then stalls and all req_ready drop.
// Ports   : req_valid/req_ready/req_a/req_b - per-requester operand handshake (32-bit lanes packed);
//           add_a/add_b -> adder, add_s/add_ovf <- adder; resp_* - shared tagged response bus;
//           issued_cnt/ovf_cnt - saturating statistics.
module fp32_add_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_s,
  input  logic                 add_ovf,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_sum,
  output logic                 resp_ovf,
  output logic [IDW-1:0]       resp_id,
  output logic [CNTW-1:0]      issued_cnt,
  output logic [CNTW-1:0]      ovf_cnt
);

  // Operand stage
  logic            op_valid_q;
  logic [31:0]     op_a_q, op_b_q;
  logic [IDW-1:0]  op_id_q;
  // Result stage
  logic            res_valid_q;
  logic [31:0]     res_sum_q;
  logic            res_ovf_q;
  logic [IDW-1:0]  res_id_q;
  // Arbitration pointer and statistics
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] issued_q, issued_d;
  logic [CNTW-1:0] ovf_q, ovf_d;

  logic            r_load, o_free, hs, resp_hs;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [31:0]     sel_a, sel_b;

  assign r_load  = op_valid_q & (~res_valid_q | resp_ready);
  assign o_free  = ~op_valid_q | r_load;
  assign resp_hs = res_valid_q & resp_ready;
  assign hs      = |req_ready;

  // Scan from ptr with wrap-around; the first active requester wins. Operands
  // are only muxed into the stage register, never into req_ready.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    ptr_d     = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found      = 1'b1;
        gnt_idx        = IDW'(idx);
        sel_a          = req_a[32*idx +: 32];
        sel_b          = req_b[32*idx +: 32];
        // Held low during reset so no requester sees an accept that gets discarded.
        req_ready[idx] = o_free & ~rst;
        if (o_free) ptr_d = IDW'((idx + 1) % NREQ);
      end
    end
  end

  assign issued_d = (hs && !(&issued_q)) ? issued_q + CNTW'(1) : issued_q;
  assign ovf_d    = (resp_hs && res_ovf_q && !(&ovf_q)) ? ovf_q + CNTW'(1) : ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= '0;
      ptr_q       <= '0;
      issued_q    <= '0;
      ovf_q       <= '0;
    end else begin
      // Result stage: load from the adder or drain on a response handshake.
      if (r_load) begin
        res_valid_q <= 1'b1;
        res_sum_q   <= add_s;
        res_ovf_q   <= add_ovf;
        res_id_q    <= op_id_q;
      end else if (resp_hs) begin
        res_valid_q <= 1'b0;
      end
      // Operand stage: refill on a grant, empty when free with nothing pending.
      if (hs) begin
        op_valid_q <= 1'b1;
        op_a_q     <= sel_a;
        op_b_q     <= sel_b;
        op_id_q    <= gnt_idx;
        ptr_q      <= ptr_d;
      end else if (o_free) begin
        op_valid_q <= 1'b0;
      end
      issued_q <= issued_d;
      ovf_q    <= ovf_d;
    end
  end

  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign resp_valid = res_valid_q;
  assign resp_sum   = res_sum_q;
  assign resp_ovf   = res_ovf_q;
  assign resp_id    = res_id_q;
  assign issued_cnt = issued_q;
  assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_fp32_add_share_ctrl.sv
// Purpose : scoreboard bench for fp32_add_share_ctrl with a lookup model of the external adder.
// Latency : driver pushes expected response on each accepted request; monitor pops on resp handshake.
// Backpr. : resp_ready driven per scenario; held responses checked for stability.
module tb_fp32_add_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         add_a, add_b, add_s;
  logic                add_ovf;
  logic                resp_valid, resp_ready;
  logic [31:0]         resp_sum;
  logic                resp_ovf;
  logic [IDW-1:0]      resp_id;
  logic [CNTW-1:0]     issued_cnt, ovf_cnt;

  fp32_add_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_ovf(add_ovf),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_ovf(resp_ovf), .resp_id(resp_id),
    .issued_cnt(issued_cnt), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: hand-computed FP32 results for the directed vectors,
  // plain integer sum for the bulk-traffic operands (distinct per op).
  function automatic logic [32:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, 1'b0};
    if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {32'h7F80_0000, 1'b1};
    if (a == 32'h3F80_0000 && b == 32'hBF80_0000) return {32'h0000_0000, 1'b0};
    return {a + b, 1'b0};
  endfunction

  always_comb {add_s, add_ovf} = adder_model(add_a, add_b);

  typedef struct packed {
    logic [31:0]    sum;
    logic           ovf;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int resp_count = 0;
  int accepted = 0;

  logic [NREQ-1:0] last_ready;
  logic            last_rv;
  logic [31:0]     last_add_a;
  logic [CNTW-1:0] last_iss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, record accepted requests into the scoreboard,
  // then return 1 time unit after the rising edge. inc_a bumps the A operand of
  // each accepted lane to form a stream of distinct operations.
  task automatic cycle(input logic inc_a);
    logic [NREQ-1:0] acc;
    logic [32:0]     r;
    exp_t            e;
    @(negedge clk);
    last_ready = req_ready;
    last_rv    = resp_valid;
    last_add_a = add_a;
    last_iss   = issued_cnt;
    acc        = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        r     = adder_model(req_a[32*i +: 32], req_b[32*i +: 32]);
        e.sum = r[32:1];
        e.ovf = r[0];
        e.id  = IDW'(i);
        exp_q.push_back(e);
        accepted++;
      end
    end
    @(posedge clk);
    #1;
    if (inc_a) begin
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) req_a[32*i +: 32] = req_a[32*i +: 32] + 32'd1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Response monitor: pops and compares on every response handshake and
  // checks that a stalled response stays unchanged.
  initial begin
    logic           hold;
    logic [31:0]    h_sum;
    logic           h_ovf;
    logic [IDW-1:0] h_id;
    exp_t           e;
    hold = 1'b0;
    h_sum = '0; h_ovf = 1'b0; h_id = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          checks++;
          if (!resp_valid || resp_sum !== h_sum || resp_ovf !== h_ovf || resp_id !== h_id) begin
            errors++;
            $display("FAIL resp_hold: got v=%0b sum=0x%0h ovf=%0b id=%0d, expected v=1 sum=0x%0h ovf=%0b id=%0d",
                     resp_valid, resp_sum, resp_ovf, resp_id, h_sum, h_ovf, h_id);
          end
        end
        if (resp_valid && resp_ready) begin
          resp_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got sum=0x%0h id=%0d, expected no response", resp_sum, resp_id);
          end else begin
            e = exp_q.pop_front();
            if (resp_sum !== e.sum || resp_ovf !== e.ovf || resp_id !== e.id) begin
              errors++;
              $display("FAIL resp_data: got sum=0x%0h ovf=%0b id=%0d, expected sum=0x%0h ovf=%0b id=%0d",
                       resp_sum, resp_ovf, resp_id, e.sum, e.ovf, e.id);
            end
          end
        end
        hold  = resp_valid && !resp_ready;
        h_sum = resp_sum;
        h_ovf = resp_ovf;
        h_id  = resp_id;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rc0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;

    // Reset state
    do_reset();
    cycle(1'b0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_sum", resp_sum, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_req_ready", req_ready, 0);

    // Single request: 1.0 + 2.0 = 3.0
    resp_ready = 1'b1;
    rc0 = resp_count;
    req_valid = 4'b0001;
    req_a[31:0] = 32'h3F80_0000;
    req_b[31:0] = 32'h4000_0000;
    cycle(1'b0);
    check("single_ready", last_ready, 4'b0001);
    req_valid = '0;
    cycle(1'b0);
    check("single_add_a", last_add_a, 32'h3F80_0000);
    check("single_not_yet", last_rv, 0);
    cycle(1'b0);
    check("single_resp_valid", last_rv, 1);
    check("single_issued", last_iss, 1);
    cycle(1'b0);
    check("single_resp_count", resp_count - rc0, 1);

    // Fairness: all requesters active
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'h0001_0000 * (i + 1);
      req_b[32*i +: 32] = i + 5;
    end
    rc0 = resp_count;
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0);
      check("rr_grant", last_ready, 32'd1 << (c % 4));
    end
    req_valid = '0;
    repeat (3) cycle(1'b0);
    check("rr_resp_count", resp_count - rc0, 12);
    check("rr_drained", exp_q.size(), 0);

    // Backpressure: stream on requester 2
    do_reset();
    resp_ready = 1'b0;
    req_a[64 +: 32] = 32'h0000_0100;
    req_b[64 +: 32] = 32'h0000_0010;
    base = accepted;
    rc0 = resp_count;
    req_valid = 4'b0100;
    repeat (5) cycle(1'b1);
    check("bp_accepted", accepted - base, 2);
    check("bp_ready_low", last_ready, 0);
    check("bp_add_a_held", add_a, 32'h0000_0101);
    check("bp_resp_sum", resp_sum, 32'h0000_0110);
    resp_ready = 1'b1;
    repeat (6) cycle(1'b1);
    req_valid = '0;
    repeat (3) cycle(1'b0);
    check("bp_total_accepted", accepted - base, 8);
    check("bp_resp_count", resp_count - rc0, 8);
    check("bp_drained", exp_q.size(), 0);

    // Overflow and cancellation
    do_reset();
    resp_ready = 1'b1;
    req_a[32 +: 32] = 32'h7F7F_FFFF;
    req_b[32 +: 32] = 32'h7F7F_FFFF;
    req_valid = 4'b0010;
    cycle(1'b0);
    check("ovf_ready", last_ready, 4'b0010);
    req_a[96 +: 32] = 32'h3F80_0000;
    req_b[96 +: 32] = 32'hBF80_0000;
    req_valid = 4'b1000;
    cycle(1'b0);
    check("cancel_ready", last_ready, 4'b1000);
    req_valid = '0;
    repeat (3) cycle(1'b0);
    check("ovf_cnt", ovf_cnt, 1);
    check("ovf_drained", exp_q.size(), 0);

    // Reset while both stages hold operations
    do_reset();
    resp_ready = 1'b0;
    req_a[31:0] = 32'h0000_0200;
    req_b[31:0] = 32'h0000_0001;
    req_valid = 4'b0001;
    repeat (3) cycle(1'b1);
    check("mid_pre_resp_valid", resp_valid, 1);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    exp_q.delete();
    check("mid_resp_valid", resp_valid, 0);
    check("mid_issued", issued_cnt, 0);
    check("mid_ovf_cnt", ovf_cnt, 0);
    check("mid_add_a", add_a, 0);
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    cycle(1'b0);
    check("mid_ptr_zero", last_ready, 4'b0001);
    req_valid = '0;
    repeat (4) cycle(1'b0);
    check("mid_drained", exp_q.size(), 0);

    // Counter saturation (4-bit counters)
    do_reset();
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0);
      if (c == 14) check("sat_issued_14", last_iss, 14);
      if (c == 16) check("sat_issued_16", last_iss, 15);
    end
    check("sat_issued_final", issued_cnt, 15);
    req_valid = '0;
    repeat (3) cycle(1'b0);
    check("sat_drained", exp_q.size(), 0);
    check("sat_issued_hold", issued_cnt, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
